action_attach: RTL and testbench
================================

# action_attach

Ingress-side producer of the per-packet action sideband consumed by the action pipeline. It classifies each Avalon-ST packet from its first beat (IPv4, VLAN+IPv4, IPv6, VLAN+IPv6) and extracts the destination IP as a lookup key. It issues one request to the forwarding table, waits for the response, then forwards the packet with `stream_out_tuser = {action_code[127:0], pkt_type[3:0]}` held constant for the whole packet.

## Interface
- `DATA_WIDTH`, 600: beat width; header is MSB-first, byte 0 at `[DATA_WIDTH-1 -: 8]`.
- `EMPTY_WIDTH`, `$clog2(DATA_WIDTH/8)`: empty field width.
- `CHANNEL_WIDTH`, 6; `ERROR_WIDTH`, 4: passthrough sideband widths.
- `ACTN_DATA_WIDTH`, 128: action code width.
- `USER_WIDTH`, `ACTN_DATA_WIDTH+4`: output tuser width.
- `DEFAULT_ACTN`, 128'h0: action applied on miss, timeout or unsupported type.
- `TIMEOUT_CYCLES`, 256: lookup wait limit (see Configuration).
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `stream_in_data/empty/valid/ready/startofpacket/endofpacket/channel/error`: Avalon-ST sink; `ready` is an output; widths per parameters.
- `stream_out_data/empty/valid/ready/startofpacket/endofpacket/channel/error`: Avalon-ST source; `ready` is an input.
- `stream_out_tuser`  out  USER_WIDTH  `{actn, pkt_type}`.
- `lkup_req_valid`  out  1; `lkup_req_ready`  in  1; `lkup_req_key`  out  128; `lkup_req_type`  out  4.
- `lkup_rsp_valid`  in  1; `lkup_rsp_hit`  in  1; `lkup_rsp_actn`  in  ACTN_DATA_WIDTH.
- `drop_count`  out  32  saturating count of orphan beats, i.e. beats arriving outside a packet.

## Operation
- Classification uses the EtherType at offset `DATA_WIDTH-112 +:16`, and the inner EtherType at `DATA_WIDTH-144 +:16` when the outer one is 0x8100.
  - 0x0800 → type 1 (IPV4); 0x8100/0x0800 → type 2 (VLV4).
  - 0x86DD → type 3 (IPV6); 0x8100/0x86DD → type 4 (VLV6).
  - Anything else → type 0.
- Lookup key source, by type:
  - IPV4: `DATA_WIDTH-272 +:32`.
  - VLV4: `DATA_WIDTH-304 +:32`.
  - IPV6: `DATA_WIDTH-432 +:128`.
  - VLV6: `DATA_WIDTH-464 +:128`.
  - IPv4 keys are zero-extended into `key[31:0]`.
- FSM states:
  - IDLE: `stream_in_ready`=1. An accepted SOP beat is captured into the head register together with its type and key. Go to REQ if type≠0, else set `actn`=DEFAULT_ACTN and go to HEAD. A non-SOP beat is consumed, discarded, and increments `drop_count`.
  - REQ: `lkup_req_valid`=1 with key and type stable. On `lkup_req_ready` go to WAIT.
  - WAIT: on `lkup_rsp_valid`, latch `actn = lkup_rsp_hit ? lkup_rsp_actn : DEFAULT_ACTN`, then go to HEAD.
  - HEAD: present the head beat with `stream_out_valid`=1. On `stream_out_ready`, go to IDLE if the beat had EOP, else go to BODY.
  - BODY: combinational pass-through. `stream_out_valid`=`stream_in_valid`, `stream_in_ready`=`stream_out_ready`, data and sideband are wired directly. The EOP handshake returns the FSM to IDLE.
- `stream_in_ready`=0 in REQ, WAIT and HEAD.
- `stream_out_tuser` is registered at HEAD entry and held until the next HEAD entry.
- Only one lookup is outstanding at a time. `lkup_rsp_valid` outside WAIT is ignored.
- A second SOP seen in BODY is treated as the continuation of the current packet; it is not re-classified.

## Timing
- Reset values: `stream_out_valid`=0, `stream_in_ready`=0 while `rst_n`=0 and 1 on the first cycle after release (IDLE), `lkup_req_valid`=0, `stream_out_tuser`=0, `drop_count`=0, FSM=IDLE, head register invalid.
- Reset mid-packet or mid-lookup aborts the packet. No partial output follows, and a late response is ignored.
- Latency from SOP accept to head output:
  - Type 0: 1 cycle.
  - Otherwise: 1 + request-wait cycles + response latency + 1.
- Body beats add 0 cycles of latency.
- Throughput: one packet header per lookup round-trip; full rate inside BODY.
- `lkup_req_valid` is held until `lkup_req_ready`; key and type must not change while it is held.
- `drop_count` saturates at 32'hFFFFFFFF.

## Configuration
- `ACTION_ATTACH_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT.
  - If `TIMEOUT_CYCLES` elapse without a response, set `actn`=DEFAULT_ACTN, set `stream_out_error[0]`=1 on every beat of that packet, and go to HEAD.
  - A response arriving after the timeout is ignored.
- Undefined: WAIT blocks indefinitely and error is pure passthrough.

## Test plan
- Single-beat IPv4 packet, EtherType 0x0800, dst 10.0.0.1; responder hit with actn=128'hA5...01 after 3 cycles → `lkup_req_key`=128'h0A000001, type 1; output tuser={actn,4'h1}; data unchanged.
- VLAN IPv6 packet of 3 beats; miss response → key from `DATA_WIDTH-464`, type 4; tuser={DEFAULT_ACTN,4'h4} on all 3 beats.
- ARP packet, EtherType 0x0806 → no request issued; head output exactly 1 cycle after accept; tuser=132'h0.
- `stream_out_ready` toggled randomly and `lkup_req_ready` held low for 5 cycles → no beat lost or duplicated; key stable while `lkup_req_valid`=1.
- Two non-SOP beats arriving in IDLE, then a valid packet → `drop_count`=2; the packet passes normally.
- With the macro defined, TIMEOUT_CYCLES=16 and no response → head output after 16 cycles in WAIT with `error[0]`=1; `rst_n` pulsed in WAIT → all outputs return to reset values.

Source files
------------

// File: rtl/action_attach_if.sv
// ----------------------------------------------------------------------------
// action_attach_if
//   Avalon-ST beat bundle used on both sides of action_attach.
//   master : drives data/empty/valid/startofpacket/endofpacket/channel/error,
//            samples ready
//   slave  : samples the beat fields, drives ready
// ----------------------------------------------------------------------------
interface action_attach_if #(
  parameter int DATA_WIDTH    = 600,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int CHANNEL_WIDTH = 6,
  parameter int ERROR_WIDTH   = 4
);
  logic [DATA_WIDTH-1:0]    data;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic                     valid;
  logic                     ready;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic [ERROR_WIDTH-1:0]   error;

  modport master (
    output data, empty, valid, startofpacket, endofpacket, channel, error,
    input  ready
  );

  modport slave (
    input  data, empty, valid, startofpacket, endofpacket, channel, error,
    output ready
  );
endinterface

// File: rtl/action_attach.sv
// ----------------------------------------------------------------------------
// action_attach
//   Classifies each packet from its first beat (IPv4 / VLAN+IPv4 / IPv6 /
//   VLAN+IPv6), looks the destination IP up in the forwarding table and
//   forwards the packet with stream_out_tuser = {action, pkt_type} held for
//   the whole packet.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stream_in           Avalon-ST sink   (action_attach_if.slave)
//   stream_out          Avalon-ST source (action_attach_if.master)
//   stream_out_tuser    {action[ACTN_DATA_WIDTH-1:0], pkt_type[3:0]}
//   lkup_req_*          lookup request (valid/ready, 128-bit key, 4-bit type)
//   lkup_rsp_*          lookup response (valid, hit, action)
//   drop_count          saturating count of beats seen outside a packet
//
// Build option
//   ACTION_ATTACH_TIMEOUT_EN : when defined, a lookup that gets no response
//   within TIMEOUT_CYCLES cycles falls back to DEFAULT_ACTN and every beat of
//   that packet leaves with error[0] set. Undefined: WAIT blocks until a
//   response arrives and error passes through untouched.
// ----------------------------------------------------------------------------
module action_attach #(
  parameter int                         DATA_WIDTH      = 600,
  parameter int                         EMPTY_WIDTH     = $clog2(DATA_WIDTH/8),
  parameter int                         CHANNEL_WIDTH   = 6,
  parameter int                         ERROR_WIDTH     = 4,
  parameter int                         ACTN_DATA_WIDTH = 128,
  parameter int                         USER_WIDTH      = ACTN_DATA_WIDTH + 4,
  parameter logic [ACTN_DATA_WIDTH-1:0] DEFAULT_ACTN    = '0,
  parameter int                         TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  action_attach_if.slave             stream_in,
  action_attach_if.master            stream_out,
  output logic [USER_WIDTH-1:0]      stream_out_tuser,
  output logic                       lkup_req_valid,
  input  logic                       lkup_req_ready,
  output logic [127:0]               lkup_req_key,
  output logic [3:0]                 lkup_req_type,
  input  logic                       lkup_rsp_valid,
  input  logic                       lkup_rsp_hit,
  input  logic [ACTN_DATA_WIDTH-1:0] lkup_rsp_actn,
  output logic [31:0]                drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HEAD,
    S_BODY
  } state_t;

  state_t state_reg, state_next;

  // Head beat captured at SOP accept
  logic [DATA_WIDTH-1:0]    head_data_reg;
  logic [EMPTY_WIDTH-1:0]   head_empty_reg;
  logic                     head_eop_reg;
  logic [CHANNEL_WIDTH-1:0] head_channel_reg;
  logic [ERROR_WIDTH-1:0]   head_error_reg;
  logic                     head_valid_reg;

  logic [3:0]               type_reg;
  logic [127:0]             key_reg;
  logic [USER_WIDTH-1:0]    tuser_reg, tuser_next;
  logic [31:0]              drop_reg;

  logic                     capture_head;
  logic                     load_tuser;
  logic                     drop_beat;
  logic                     in_ready;
  logic [ERROR_WIDTH-1:0]   error_force;

  // --------------------------------------------------------------------------
  // First-beat classification and key extraction (only used on SOP in IDLE)
  // --------------------------------------------------------------------------
  logic [15:0]  outer_ethertype;
  logic [15:0]  inner_ethertype;
  logic [3:0]   sop_type;
  logic [127:0] sop_key;

  always_comb begin
    outer_ethertype = stream_in.data[DATA_WIDTH-112 +: 16];
    inner_ethertype = stream_in.data[DATA_WIDTH-144 +: 16];
    sop_type        = 4'd0;
    sop_key         = '0;
    if (outer_ethertype == 16'h0800) begin
      sop_type = 4'd1;
      sop_key  = {96'h0, stream_in.data[DATA_WIDTH-272 +: 32]};
    end else if (outer_ethertype == 16'h86DD) begin
      sop_type = 4'd3;
      sop_key  = stream_in.data[DATA_WIDTH-432 +: 128];
    end else if (outer_ethertype == 16'h8100) begin
      if (inner_ethertype == 16'h0800) begin
        sop_type = 4'd2;
        sop_key  = {96'h0, stream_in.data[DATA_WIDTH-304 +: 32]};
      end else if (inner_ethertype == 16'h86DD) begin
        sop_type = 4'd4;
        sop_key  = stream_in.data[DATA_WIDTH-464 +: 128];
      end
    end
  end

`ifdef ACTION_ATTACH_TIMEOUT_EN
  logic [15:0] wait_cnt_reg;
  logic        timeout_err_reg;
  logic        timeout_hit;
`endif

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    in_ready       = 1'b0;
    stream_out.valid = 1'b0;
    lkup_req_valid = 1'b0;
    capture_head   = 1'b0;
    load_tuser     = 1'b0;
    drop_beat      = 1'b0;
    tuser_next     = tuser_reg;
`ifdef ACTION_ATTACH_TIMEOUT_EN
    timeout_hit    = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (stream_in.valid) begin
          if (stream_in.startofpacket) begin
            capture_head = 1'b1;
            if (sop_type != 4'd0) begin
              state_next = S_REQ;
            end else begin
              // Unsupported type skips the lookup entirely
              load_tuser = 1'b1;
              tuser_next = {DEFAULT_ACTN, 4'h0};
              state_next = S_HEAD;
            end
          end else begin
            drop_beat = 1'b1;
          end
        end
      end
      S_REQ: begin
        lkup_req_valid = 1'b1;
        if (lkup_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (lkup_rsp_valid) begin
          load_tuser = 1'b1;
          tuser_next = {(lkup_rsp_hit ? lkup_rsp_actn : DEFAULT_ACTN), type_reg};
          state_next = S_HEAD;
        end
`ifdef ACTION_ATTACH_TIMEOUT_EN
        else if (wait_cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
          load_tuser  = 1'b1;
          tuser_next  = {DEFAULT_ACTN, type_reg};
          timeout_hit = 1'b1;
          state_next  = S_HEAD;
        end
`endif
      end
      S_HEAD: begin
        stream_out.valid = head_valid_reg;
        if (head_valid_reg && stream_out.ready)
          state_next = head_eop_reg ? S_IDLE : S_BODY;
      end
      S_BODY: begin
        stream_out.valid = stream_in.valid;
        in_ready         = stream_out.ready;
        if (stream_in.valid && stream_out.ready && stream_in.endofpacket)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The FSM already sits in IDLE during reset; ready must still read 0 then.
  assign stream_in.ready = in_ready & rst_n;

  // --------------------------------------------------------------------------
  // Output beat mux: stored head beat in HEAD, straight wires in BODY
  // --------------------------------------------------------------------------
  always_comb begin
    if (state_reg == S_BODY) begin
      stream_out.data          = stream_in.data;
      stream_out.empty         = stream_in.empty;
      stream_out.startofpacket = stream_in.startofpacket;
      stream_out.endofpacket   = stream_in.endofpacket;
      stream_out.channel       = stream_in.channel;
      stream_out.error         = stream_in.error | error_force;
    end else begin
      stream_out.data          = head_data_reg;
      stream_out.empty         = head_empty_reg;
      stream_out.startofpacket = head_valid_reg;
      stream_out.endofpacket   = head_eop_reg;
      stream_out.channel       = head_channel_reg;
      stream_out.error         = head_error_reg | error_force;
    end
  end

  assign stream_out_tuser = tuser_reg;
  assign lkup_req_key     = key_reg;
  assign lkup_req_type    = type_reg;
  assign drop_count       = drop_reg;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      head_data_reg    <= '0;
      head_empty_reg   <= '0;
      head_eop_reg     <= 1'b0;
      head_channel_reg <= '0;
      head_error_reg   <= '0;
      head_valid_reg   <= 1'b0;
      type_reg         <= '0;
      key_reg          <= '0;
      tuser_reg        <= '0;
      drop_reg         <= '0;
    end else begin
      state_reg <= state_next;
      if (capture_head) begin
        head_data_reg    <= stream_in.data;
        head_empty_reg   <= stream_in.empty;
        head_eop_reg     <= stream_in.endofpacket;
        head_channel_reg <= stream_in.channel;
        head_error_reg   <= stream_in.error;
        head_valid_reg   <= 1'b1;
        type_reg         <= sop_type;
        key_reg          <= sop_key;
      end else if (state_reg == S_HEAD && stream_out.ready) begin
        head_valid_reg <= 1'b0;
      end
      if (load_tuser) tuser_reg <= tuser_next;
      if (drop_beat && drop_reg != 32'hFFFF_FFFF) drop_reg <= drop_reg + 32'd1;
    end
  end

`ifdef ACTION_ATTACH_TIMEOUT_EN
  // Counts cycles spent in WAIT; restarts whenever the FSM is elsewhere so a
  // response arriving after the timeout finds the FSM outside WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == S_WAIT) wait_cnt_reg <= wait_cnt_reg + 16'd1;
      else                     wait_cnt_reg <= '0;
      if (capture_head)      timeout_err_reg <= 1'b0;
      else if (timeout_hit)  timeout_err_reg <= 1'b1;
    end
  end

  assign error_force = {{(ERROR_WIDTH-1){1'b0}}, timeout_err_reg};
`else
  assign error_force = '0;
`endif

endmodule

// File: tb/tb_action_attach.sv
`timescale 1ns/1ps
module tb_action_attach;
  localparam int DW  = 600;
  localparam int EW  = $clog2(DW/8);
  localparam int CW  = 6;
  localparam int ERW = 4;
  localparam int AW  = 128;
  localparam int UW  = AW + 4;
  localparam logic [AW-1:0] DEF_ACTN = '0;
  localparam logic [AW-1:0] HIT_ACTN = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501;
  localparam logic [AW-1:0] ALT_ACTN = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  action_attach_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .ERROR_WIDTH(ERW)) s_in ();
  action_attach_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .ERROR_WIDTH(ERW)) s_out ();

  logic [UW-1:0]  tuser;
  logic           lkup_req_valid, lkup_req_ready;
  logic [127:0]   lkup_req_key;
  logic [3:0]     lkup_req_type;
  logic           lkup_rsp_valid, lkup_rsp_hit;
  logic [AW-1:0]  lkup_rsp_actn;
  logic [31:0]    drop_count;

  action_attach #(
    .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .ERROR_WIDTH(ERW),
    .ACTN_DATA_WIDTH(AW), .USER_WIDTH(UW), .DEFAULT_ACTN(DEF_ACTN), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stream_in(s_in), .stream_out(s_out),
    .stream_out_tuser(tuser),
    .lkup_req_valid(lkup_req_valid), .lkup_req_ready(lkup_req_ready),
    .lkup_req_key(lkup_req_key), .lkup_req_type(lkup_req_type),
    .lkup_rsp_valid(lkup_rsp_valid), .lkup_rsp_hit(lkup_rsp_hit), .lkup_rsp_actn(lkup_rsp_actn),
    .drop_count(drop_count)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0]  data;
    logic [EW-1:0]  empty;
    logic           sop;
    logic           eop;
    logic [CW-1:0]  ch;
    logic [ERW-1:0] err;
    logic [UW-1:0]  user;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  // ---------------- monitors (sample on negedge) ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int  out_beats = 0;
  int  req_count = 0;
  int  acc_cyc = 0, head_cyc = 0, fire_cyc = 0;
  bit  head_seen = 1'b0;
  bit  req_held = 1'b0;
  logic [127:0] held_key, last_key;
  logic [3:0]   held_type, last_type;

  always @(negedge clk) begin
    if (s_out.valid && s_out.ready) begin
      out_beats++;
      check("beat_expected", 600'(exp_q.size() != 0), 600'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_data", s_out.data, mon_e.data);
        check("out_ctl", {s_out.startofpacket, s_out.endofpacket, s_out.empty, s_out.channel, s_out.error},
              {mon_e.sop, mon_e.eop, mon_e.empty, mon_e.ch, mon_e.err});
        check("out_tuser", tuser, mon_e.user);
      end
      $display("beat %0d sop=%0b eop=%0b ch=%0h err=%0h tuser=%0h", out_beats,
               s_out.startofpacket, s_out.endofpacket, s_out.channel, s_out.error, tuser);
    end
    if (s_out.valid && s_out.startofpacket && !head_seen) begin
      head_seen = 1'b1;
      head_cyc  = cyc;
    end
    if (s_in.valid && s_in.ready && s_in.startofpacket) begin
      acc_cyc   = cyc;
      head_seen = 1'b0;
    end
    if (lkup_req_valid) begin
      if (req_held) begin
        check("req_key_stable", lkup_req_key, held_key);
        check("req_type_stable", lkup_req_type, held_type);
      end
      held_key  = lkup_req_key;
      held_type = lkup_req_type;
      req_held  = !lkup_req_ready;
      if (lkup_req_ready) begin
        req_count++;
        last_key  = lkup_req_key;
        last_type = lkup_req_type;
        fire_cyc  = cyc;
      end
    end else begin
      req_held = 1'b0;
    end
  end

  // ---------------- lookup responder ----------------
  int   rsp_delay = 3;
  bit   rsp_hit = 1'b1;
  bit   rsp_en = 1'b1;
  int   rdy_hold = 0;
  logic [AW-1:0] rsp_actn = HIT_ACTN;
  int   r_seen, r_cnt, r_hold;

  initial begin
    lkup_req_ready = 1'b0; lkup_rsp_valid = 1'b0; lkup_rsp_hit = 1'b0; lkup_rsp_actn = '0;
    r_seen = 0; r_cnt = 0; r_hold = 0;
    forever begin
      @(posedge clk); #1;
      lkup_rsp_valid = 1'b0;
      if (req_count != r_seen) begin
        r_seen = req_count;
        lkup_req_ready = 1'b0;
        r_cnt  = rsp_delay;
        r_hold = 0;
      end else if (lkup_req_valid && !lkup_req_ready) begin
        if (r_hold >= rdy_hold) lkup_req_ready = 1'b1;
        else r_hold++;
      end
      if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0 && rsp_en) begin
          lkup_rsp_valid = 1'b1;
          lkup_rsp_hit   = rsp_hit;
          lkup_rsp_actn  = rsp_actn;
        end
      end
    end
  end

  // ---------------- output ready driver ----------------
  bit rand_ready = 1'b0;
  initial begin
    s_out.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      s_out.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Builds an Ethernet header byte by byte (byte 0 at the MSB end).
  function automatic logic [DW-1:0] mk_hdr(input logic [15:0] et_outer, input bit vlan,
                                           input logic [15:0] et_inner, input bit v6,
                                           input logic [127:0] dst);
    logic [7:0]    b [75];
    logic [DW-1:0] h;
    int l3, off;
    for (int i = 0; i < 75; i++) b[i] = 8'(i * 7 + 3);
    b[12] = et_outer[15:8]; b[13] = et_outer[7:0];
    l3 = 14;
    if (vlan) begin
      b[14] = 8'h00; b[15] = 8'h05;
      b[16] = et_inner[15:8]; b[17] = et_inner[7:0];
      l3 = 18;
    end
    if (v6) begin
      off = l3 + 24;
      for (int i = 0; i < 16; i++) b[off+i] = dst[127-8*i -: 8];
    end else begin
      off = l3 + 16;
      for (int i = 0; i < 4; i++) b[off+i] = dst[31-8*i -: 8];
    end
    h = '0;
    for (int i = 0; i < 75; i++) h[DW-1-8*i -: 8] = b[i];
    return h;
  endfunction

  function automatic logic [DW-1:0] body_beat(input int i);
    logic [7:0] bv;
    bv = 8'(8'h30 + i);
    return {75{bv}};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
  task automatic drive_beat(input logic [DW-1:0] d, input bit sop, input bit eop,
                            input logic [EW-1:0] emp, input logic [CW-1:0] ch,
                            input logic [ERW-1:0] err);
    int  n = 0;
    bit  ok = 1'b0;
    s_in.data = d; s_in.startofpacket = sop; s_in.endofpacket = eop;
    s_in.empty = emp; s_in.channel = ch; s_in.error = err; s_in.valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_in.ready;
      n++;
    end
    check("in_accept", 600'(ok), 600'(1));
    @(posedge clk); #1;
    s_in.valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] hdr, input int nbeats, input logic [CW-1:0] ch,
                          input logic [ERW-1:0] err, input logic [UW-1:0] user,
                          input bit expect_out, input logic [ERW-1:0] err_or);
    beat_t e;
    logic [DW-1:0] d;
    logic [EW-1:0] emp;
    for (int i = 0; i < nbeats; i++) begin
      d   = (i == 0) ? hdr : body_beat(i);
      emp = (i == nbeats - 1) ? EW'(5) : EW'(0);
      if (expect_out) begin
        e.data = d; e.empty = emp; e.sop = (i == 0); e.eop = (i == nbeats - 1);
        e.ch = ch; e.err = err | err_or; e.user = user;
        exp_q.push_back(e);
      end
      drive_beat(d, i == 0, i == nbeats - 1, emp, ch, err);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 600'(exp_q.size()), 600'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  600'(s_in.ready), 600'(0));
    check({tag, "_out_valid"}, 600'(s_out.valid), 600'(0));
    check({tag, "_req_valid"}, 600'(lkup_req_valid), 600'(0));
    check({tag, "_tuser"},     600'(tuser), 600'(0));
    check({tag, "_drop"},      600'(drop_count), 600'(0));
  endtask

  // ---------------- main sequence ----------------
  int base_req, base_beats, n;

  initial begin
    s_in.valid = 1'b0; s_in.data = '0; s_in.startofpacket = 1'b0; s_in.endofpacket = 1'b0;
    s_in.empty = '0; s_in.channel = '0; s_in.error = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 600'(s_in.ready), 600'(1));
    @(posedge clk); #1;

    // 1: single-beat IPv4 10.0.0.1, hit after 3 cycles
    rsp_delay = 3; rsp_hit = 1'b1; rsp_actn = HIT_ACTN;
    send_pkt(mk_hdr(16'h0800, 1'b0, 16'h0, 1'b0, 128'h0A000001), 1, 6'h11, 4'h0,
             {HIT_ACTN, 4'h1}, 1'b1, 4'h0);
    wait_drain();
    check("ipv4_key", last_key, 128'h0A000001);
    check("ipv4_type", 600'(last_type), 600'(1));
    check("ipv4_req_count", 600'(req_count), 600'(1));
    check("ipv4_tuser_hold", tuser, {HIT_ACTN, 4'h1});

    // 2: VLAN IPv6, 3 beats, miss
    rsp_hit = 1'b0; rsp_actn = ALT_ACTN;
    send_pkt(mk_hdr(16'h8100, 1'b1, 16'h86DD, 1'b1, 128'h20010DB8_00000000_00000000_00000042), 3,
             6'h2A, 4'h2, {DEF_ACTN, 4'h4}, 1'b1, 4'h0);
    wait_drain();
    check("vlv6_key", last_key, 128'h20010DB8_00000000_00000000_00000042);
    check("vlv6_type", 600'(last_type), 600'(4));

    // 3: ARP, no lookup, head one cycle after accept
    base_req = req_count;
    send_pkt(mk_hdr(16'h0806, 1'b0, 16'h0, 1'b0, 128'h0), 2, 6'h03, 4'h0,
             {DEF_ACTN, 4'h0}, 1'b1, 4'h0);
    wait_drain();
    check("arp_no_req", 600'(req_count), 600'(base_req));
    check("arp_latency", 600'(head_cyc - acc_cyc), 600'(1));
    check("arp_tuser", tuser, 600'(0));

    // 4: VLAN IPv4, random output ready, request ready held off 5 cycles
    rand_ready = 1'b1; rdy_hold = 5; rsp_hit = 1'b1; rsp_actn = ALT_ACTN; rsp_delay = 2;
    send_pkt(mk_hdr(16'h8100, 1'b1, 16'h0800, 1'b0, 128'hC0A80107), 4, 6'h05, 4'h8,
             {ALT_ACTN, 4'h2}, 1'b1, 4'h0);
    wait_drain();
    rand_ready = 1'b0; rdy_hold = 0;
    check("vlv4_key", last_key, 128'hC0A80107);
    check("vlv4_type", 600'(last_type), 600'(2));

    // 5: two orphan beats, then an IPv6 packet
    drive_beat(body_beat(7), 1'b0, 1'b0, '0, 6'h01, 4'h0);
    drive_beat(body_beat(8), 1'b0, 1'b1, '0, 6'h01, 4'h0);
    check("drop_count_2", 600'(drop_count), 600'(2));
    rsp_actn = HIT_ACTN;
    send_pkt(mk_hdr(16'h86DD, 1'b0, 16'h0, 1'b1, 128'hFE800000_00000000_02AABBFF_FECCDDEE), 2,
             6'h07, 4'h0, {HIT_ACTN, 4'h3}, 1'b1, 4'h0);
    wait_drain();
    check("ipv6_key", last_key, 128'hFE800000_00000000_02AABBFF_FECCDDEE);
    check("ipv6_type", 600'(last_type), 600'(3));
    check("drop_count_after", 600'(drop_count), 600'(2));

`ifdef ACTION_ATTACH_TIMEOUT_EN
    // 6: no response -> timeout after 16 WAIT cycles, error[0] on every beat
    rsp_en = 1'b0;
    send_pkt(mk_hdr(16'h0800, 1'b0, 16'h0, 1'b0, 128'h0A000002), 2, 6'h09, 4'h4,
             {DEF_ACTN, 4'h1}, 1'b1, 4'h1);
    wait_drain();
    check("timeout_wait", 600'(head_cyc - fire_cyc), 600'(17));
    rsp_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
`endif

    // 7: reset while waiting for a response; late response must be ignored
    rsp_delay = 20;
    base_req = req_count;
    base_beats = out_beats;
    send_pkt(mk_hdr(16'h0800, 1'b0, 16'h0, 1'b0, 128'h0A000003), 1, 6'h0C, 4'h0,
             '0, 1'b0, 4'h0);
    n = 0;
    while (req_count == base_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_test_req", 600'(req_count), 600'(base_req + 1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_beat_after_rst", 600'(out_beats), 600'(base_beats));
    rsp_delay = 2;

    // 8: normal traffic resumes
    send_pkt(mk_hdr(16'h0806, 1'b0, 16'h0, 1'b0, 128'h0), 1, 6'h01, 4'h0,
             {DEF_ACTN, 4'h0}, 1'b1, 4'h0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
